heads_up_collision_detector: RTL and testbench

HEADS_UP_COLLISION_DETECTOR -- requirements
Module: heads_up_collision_detector

---
 rtl/heads_up_pkg.sv | 24 ++
 rtl/heads_up_priority_enc.sv | 30 +++
 rtl/heads_up_collision_detector.sv | 150 +++++++++++++++
 tb/tb_heads_up_collision_detector.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/heads_up_pkg.sv
`default_nettype none
// ============================================================================
// Module   : heads_up_pkg
// Purpose  : Shared types and sizing for the heads-up collision detector.
// Revision : 1.0 - initial release
// ============================================================================
package heads_up_pkg;

  localparam int DEFAULT_NUM_ENEMIES = 4;
  localparam int OVL_CNT_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_e;

  // Index width that stays legal when only one enemy is configured.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/heads_up_priority_enc.sv
`default_nettype none
// ============================================================================
// Module   : heads_up_priority_enc
// Purpose  : Overlap flag and lowest-set enemy index for the current pixel.
// Revision : 1.0 - initial release
// ============================================================================
module heads_up_priority_enc
  import heads_up_pkg::*;
#(
  parameter int NUM_ENEMIES = DEFAULT_NUM_ENEMIES,
  parameter int IDX_W       = idx_width(NUM_ENEMIES)
) (
  input  logic                   player_i,
  input  logic [NUM_ENEMIES-1:0] heads_up_i,
  output logic                   overlap_o,
  output logic [IDX_W-1:0]       index_o
);

  assign overlap_o = player_i & (|heads_up_i);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    index_o = '0;
    for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
      if (heads_up_i[i]) index_o = IDX_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/heads_up_collision_detector.sv
`default_nettype none
// ============================================================================
// Module   : heads_up_collision_detector
// Purpose  : Per-frame player/heads-up overlap counting with hit report and cooldown.
// Revision : 1.0 - initial release
// ============================================================================
module heads_up_collision_detector
  import heads_up_pkg::*;
#(
  parameter int NUM_ENEMIES        = DEFAULT_NUM_ENEMIES,
  parameter int MIN_OVERLAP_PIXELS = 4,
  parameter int COOLDOWN_FRAMES    = 30
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic                               startOfFrame,
  input  logic [10:0]                        pixelX,
  input  logic [10:0]                        pixelY,
  input  logic                               enable,
  input  logic                               playerDrawingRequest,
  input  logic [NUM_ENEMIES-1:0]             headsUpDrawingRequest,
  output logic                               collisionPulse,
  output logic [idx_width(NUM_ENEMIES)-1:0]  collisionIndex,
  output logic [10:0]                        collisionX,
  output logic [10:0]                        collisionY,
  output logic                               inCooldown
);

  localparam int IDX_W = idx_width(NUM_ENEMIES);
  localparam int CD_W  = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [OVL_CNT_W-1:0] c_min_ovl = OVL_CNT_W'(MIN_OVERLAP_PIXELS);
  localparam logic [CD_W-1:0]      c_cd_load = CD_W'(COOLDOWN_FRAMES);
  localparam logic [CD_W-1:0]      c_cd_one  = CD_W'(1);

  state_e               state_q, state_d;
  logic [CD_W-1:0]      cd_cnt_q, cd_cnt_d;
  logic [OVL_CNT_W-1:0] ovl_cnt_q;
  logic                 first_q;
  logic [IDX_W-1:0]     hit_idx_q;
  logic [10:0]          hit_x_q, hit_y_q;
  logic                 pulse_q;
  logic [IDX_W-1:0]     out_idx_q;
  logic [10:0]          out_x_q, out_y_q;

  logic                 overlap;
  logic [IDX_W-1:0]     low_idx;
  logic                 fire;
  logic                 count_en;
  logic                 clr_frame;

  heads_up_priority_enc #(
    .NUM_ENEMIES (NUM_ENEMIES),
    .IDX_W       (IDX_W)
  ) u_prio (
    .player_i   (playerDrawingRequest),
    .heads_up_i (headsUpDrawingRequest),
    .overlap_o  (overlap),
    .index_o    (low_idx)
  );

  always_comb begin
    state_d  = state_q;
    cd_cnt_d = cd_cnt_q;
    fire     = 1'b0;
    if (!enable) begin
      state_d  = ST_IDLE;
      cd_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (startOfFrame) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (startOfFrame && (ovl_cnt_q >= c_min_ovl)) begin
            fire     = 1'b1;
            state_d  = ST_COOLDOWN;
            cd_cnt_d = c_cd_load;
          end
        end
        ST_COOLDOWN: begin
          if (startOfFrame) begin
            if (cd_cnt_q <= c_cd_one) begin
              state_d  = ST_ARMED;
              cd_cnt_d = '0;
            end else begin
              cd_cnt_d = cd_cnt_q - c_cd_one;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A pixel counts only toward a frame that is armed; the first armed frame
  // after IDLE starts empty even if its strobe carries an overlap.
  assign count_en  = overlap && (state_d == ST_ARMED) && (state_q != ST_IDLE);
  assign clr_frame = startOfFrame || !enable;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      cd_cnt_q  <= '0;
      ovl_cnt_q <= '0;
      first_q   <= 1'b0;
      hit_idx_q <= '0;
      hit_x_q   <= '0;
      hit_y_q   <= '0;
      pulse_q   <= 1'b0;
      out_idx_q <= '0;
      out_x_q   <= '0;
      out_y_q   <= '0;
    end else begin
      state_q  <= state_d;
      cd_cnt_q <= cd_cnt_d;
      pulse_q  <= fire;
      if (fire) begin
        out_idx_q <= hit_idx_q;
        out_x_q   <= hit_x_q;
        out_y_q   <= hit_y_q;
      end
      if (clr_frame) begin
        ovl_cnt_q <= count_en ? OVL_CNT_W'(1) : '0;
        first_q   <= count_en;
        if (count_en) begin
          hit_idx_q <= low_idx;
          hit_x_q   <= pixelX;
          hit_y_q   <= pixelY;
        end
      end else if (count_en) begin
        if (ovl_cnt_q != '1) ovl_cnt_q <= ovl_cnt_q + OVL_CNT_W'(1);
        if (!first_q) begin
          first_q   <= 1'b1;
          hit_idx_q <= low_idx;
          hit_x_q   <= pixelX;
          hit_y_q   <= pixelY;
        end
      end
    end
  end

  assign collisionPulse = pulse_q;
  assign collisionIndex = out_idx_q;
  assign collisionX     = out_x_q;
  assign collisionY     = out_y_q;
  assign inCooldown     = (state_q == ST_COOLDOWN);

endmodule
`default_nettype wire

// File: tb/tb_heads_up_collision_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_heads_up_collision_detector
// Purpose  : Directed bench for the heads-up collision detector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_heads_up_collision_detector;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX, pixelY;
  logic        enable;
  logic        playerDrawingRequest;
  logic [3:0]  headsUpDrawingRequest;
  logic        collisionPulse;
  logic [1:0]  collisionIndex;
  logic [10:0] collisionX, collisionY;
  logic        inCooldown;

  int total  = 0;
  int passed = 0;

  heads_up_collision_detector #(
    .NUM_ENEMIES        (4),
    .MIN_OVERLAP_PIXELS (4),
    .COOLDOWN_FRAMES    (2)
  ) dut (
    .clk                   (clk),
    .resetN                (resetN),
    .startOfFrame          (startOfFrame),
    .pixelX                (pixelX),
    .pixelY                (pixelY),
    .enable                (enable),
    .playerDrawingRequest  (playerDrawingRequest),
    .headsUpDrawingRequest (headsUpDrawingRequest),
    .collisionPulse        (collisionPulse),
    .collisionIndex        (collisionIndex),
    .collisionX            (collisionX),
    .collisionY            (collisionY),
    .inCooldown            (inCooldown)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One pixel cycle: drive, let the DUT sample it, then return the strobes low.
  task automatic px(input bit sof, input bit pl, input int hu, input int x, input int y);
    startOfFrame          = sof;
    playerDrawingRequest  = pl;
    headsUpDrawingRequest = 4'(hu);
    pixelX                = 11'(x);
    pixelY                = 11'(y);
    @(posedge clk);
    #1;
    startOfFrame          = 1'b0;
    playerDrawingRequest  = 1'b0;
    headsUpDrawingRequest = '0;
  endtask

  task automatic check_outs(input string tag, input int p, input int idx,
                            input int x, input int y, input int cd);
    check({tag, "_pulse"}, 32'(collisionPulse), p);
    check({tag, "_idx"},   32'(collisionIndex), idx);
    check({tag, "_x"},     32'(collisionX), x);
    check({tag, "_y"},     32'(collisionY), y);
    check({tag, "_cd"},    32'(inCooldown), cd);
  endtask

  initial begin
    resetN = 1'b0; enable = 1'b0; startOfFrame = 1'b0;
    playerDrawingRequest = 1'b0; headsUpDrawingRequest = '0;
    pixelX = '0; pixelY = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0);
    resetN = 1'b1;
    enable = 1'b1;

    // Basic hit: arm, empty frame, 5 overlaps on enemy 2 from (100,200).
    px(1, 0, 0, 0, 0);
    check("arm_pulse", 32'(collisionPulse), 0);
    px(1, 0, 0, 0, 0);
    check("empty_frame_pulse", 32'(collisionPulse), 0);
    for (int i = 0; i < 5; i++) px(0, 1, 4'b0100, 100 + i, 200);
    px(1, 0, 0, 0, 0);
    check_outs("hit1", 1, 2, 100, 200, 1);
    px(0, 0, 0, 0, 0);
    check_outs("hit1_after", 0, 2, 100, 200, 1);

    // Two cooldown frames ignore heavy overlap.
    for (int i = 0; i < 10; i++) px(0, 1, 4'b0001, i, i);
    px(1, 0, 0, 0, 0);
    check_outs("cd_frame1", 0, 2, 100, 200, 1);
    for (int i = 0; i < 10; i++) px(0, 1, 4'b0001, i, i);
    px(1, 0, 0, 0, 0);
    check_outs("cd_frame2", 0, 2, 100, 200, 0);

    // Frame 3: enemies 1 and 3 both on the first overlap pixel.
    px(0, 1, 4'b1010, 50, 60);
    for (int i = 0; i < 3; i++) px(0, 1, 4'b0001, 70 + i, 80);
    px(1, 0, 0, 0, 0);
    check_outs("hit2", 1, 1, 50, 60, 1);
    px(0, 0, 0, 0, 0);
    check("hit2_one_cycle", 32'(collisionPulse), 0);

    // Dropping enable leaves cooldown at once.
    enable = 1'b0;
    px(0, 0, 0, 0, 0);
    check("disable_cd", 32'(inCooldown), 0);
    enable = 1'b1;
    px(1, 0, 0, 0, 0);

    // 3 overlaps are short; the overlap on the strobe belongs to the next frame.
    for (int i = 0; i < 3; i++) px(0, 1, 4'b0001, 10 + i, 20);
    px(1, 1, 4'b1000, 300, 400);
    check_outs("short_frame", 0, 1, 50, 60, 0);
    for (int i = 0; i < 3; i++) px(0, 1, 4'b0001, 5, 5);
    px(1, 0, 0, 0, 0);
    check_outs("sof_overlap_hit", 1, 3, 300, 400, 1);

    // Asynchronous reset mid-frame discards the accumulated overlaps.
    enable = 1'b0;
    px(0, 0, 0, 0, 0);
    enable = 1'b1;
    px(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) px(0, 1, 4'b0010, 30 + i, 40);
    #2;
    resetN = 1'b0;
    #1;
    check_outs("async_reset", 0, 0, 0, 0, 0);
    resetN = 1'b1;
    px(1, 0, 0, 0, 0);
    check_outs("post_reset_sof", 0, 0, 0, 0, 0);
    px(0, 1, 4'b0010, 1, 1);
    px(1, 0, 0, 0, 0);
    check_outs("post_reset_frame", 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
